ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
Decodes a WS2812-format serial line (NRZ pulse-width code, GRB MSB-first, frame terminated by a long low reset code) into 24-bit pixel words. It is the receive counterpart of the LED transmit path and is used for loopback self-test of the transmitter and for daisy-chain input capture. Decoded pixels are presented as a one-cycle-valid stream with a 6-bit index, directly usable as write address/data for a 64-entry pixel RAM.

Parameters:
HI_MIN, 8, minimum legal high-pulse length in clk cycles; shorter is a glitch error.
HI_THR, 30, high length >= HI_THR decodes as 1, otherwise 0.
HI_MAX, 60, maximum legal high-pulse length; longer is an error.
PIX_MAX, 64, pixels accepted per frame; later pixels are dropped.

Ports:
clk_in  input  1  system clock (50 MHz nominal)
rst_n_in  input  1  asynchronous active-low reset
din_in  input  1  raw WS2812 line, asynchronous to clk_in
rst_cnt_in  input  16  reset-code length in units of 2 clk cycles
pix_valid_out  output  1  one-cycle pulse: pix_data_out/pix_idx_out valid
pix_data_out  output  24  decoded pixel, bit 23 = first received bit
pix_idx_out  output  6  pixel index within frame, 0..63
pix_cnt_out  output  7  complete pixels in last finished frame, 0..64
frame_done_out  output  1  one-cycle pulse at end of a good frame
ovf_out  output  1  last finished frame had more than PIX_MAX pixels
err_out  output  1  one-cycle pulse on any decode error
busy_out  output  1  high while in RECV

Behaviour:
- Reset: rst_n_in is asynchronous, active-low; clock is clk_in. All outputs and all counters clear to 0; state = SYNC.
- Input path: din_in passes through 2 flops to give din_s, plus a third flop din_d. Rise = din_s & ~din_d; fall = ~din_s & din_d.
- hi_cnt: cleared on rise, +1 per cycle while din_s=1, saturates at HI_MAX+1. On a fall, hi_len = hi_cnt.
- lo_cnt (17 bit): cleared on fall, +1 per cycle while din_s=0, saturating. rst_hit = (lo_cnt >= max({rst_cnt_in,1'b0}, 2)). rst_cnt_in is sampled live, so changing it mid-low takes effect immediately.
- States:
  - SYNC: wait for rst_hit, then go to IDLE. A high line or high pulses never leave SYNC. This prevents decoding from mid-frame.
  - IDLE: on rise go to RECV; bit_cnt = 0, pix_idx = 0.
  - RECV: on each fall, classify the bit.
    - hi_len < HI_MIN or hi_len > HI_MAX: err_out pulse; go to SYNC; discard the partial pixel and the frame (no frame_done).
    - Otherwise: shift the bit into the shift register (LSB in); bit_cnt +1.
    - When bit_cnt reaches 24 (fall of the 24th bit):
      - If pix_idx < PIX_MAX: on the next cycle, pix_valid_out = 1, pix_data_out = shift value, pix_idx_out = pix_idx.
      - Otherwise: set internal ovf flag; no pix_valid.
      - In both cases pix_idx +1 (7-bit, saturates at 64); bit_cnt = 0.
    - On rst_hit in RECV, the frame ends:
      - If bit_cnt == 0: frame_done_out pulse, pix_cnt_out = min(pix_idx, 64), ovf_out = ovf flag. Go to IDLE.
      - If bit_cnt != 0 (partial pixel): err_out pulse, no frame_done, pix_cnt_out/ovf_out unchanged. Go to IDLE.
    - The internal ovf flag clears on entry to RECV.
  - A held-high line in RECV: hi_cnt saturates, and the eventual fall is classified as an error.
- Latency: pix_valid_out rises 1 cycle after the registered fall of bit 24, i.e. 4 clk after the din_in edge.
- pix_data_out and pix_idx_out hold their last value between pulses.
- frame_done_out and err_out are registered single-cycle pulses; they never assert in the same cycle.
- A low gap longer than a normal bit but shorter than the reset code is legal (no error).
- Asynchronous reset mid-frame returns to SYNC; a frame already on the wire is ignored until the next reset code.

Decomposition:
- ws2812_pkg holds:
  - rx state enum {SYNC, IDLE, RECV};
  - typedef pixel_t (24 bit);
  - default timing constants HI_MIN/HI_THR/HI_MAX shared with the transmit path;
  - PIX_MAX = 64.
- Sub-module ws2812_rx_sync: 2-flop synchronizer plus edge flop. Outputs din_s, rise, fall. Same clock/reset convention.
- Everything else lives in ws2812_rx: counters, FSM, shift register.

Test Plan:
1. Reset; hold din low 3000 clk (rst_cnt_in=1500); send GRB 0xFF0080 with bits of 0 = 20 hi/42 lo and 1 = 40 hi/22 lo; low 3000 -> one pix_valid with data 0xFF0080, idx 0; then frame_done, pix_cnt_out=1, ovf_out=0, err_out never.
2. After sync, send 65 pixels (value = index) then reset code -> 64 pix_valid, idx 0..63, data 0..63; frame_done; pix_cnt_out=64; ovf_out=1.
3. Mid-pixel, a 4-cycle high glitch -> err_out pulse; busy_out=0; 2 further pixels without a reset code -> no pix_valid; after reset code plus 1 pixel -> normal decode.
4. 10 bits then 3000 low -> err_out pulse; no pix_valid; no frame_done; pix_cnt_out keeps its previous value.
5. Power-up with din high, then a pixel stream without a leading reset code -> no pix_valid until the first 3000-cycle low.
6. Assert rst_n_in at bit 12 of pixel 3 -> all outputs 0 within the same cycle; state SYNC; remaining bits ignored.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 types and timing defaults.
// Used by both the transmit and receive paths.
package ws2812_pkg;

   typedef enum logic [1:0] {
      SYNC,
      IDLE,
      RECV
   } rx_state_e;

   typedef logic [23:0] pixel_t;

   localparam int DEF_HI_MIN  = 8;
   localparam int DEF_HI_THR  = 30;
   localparam int DEF_HI_MAX  = 60;
   localparam int DEF_PIX_MAX = 64;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the raw WS2812 line.
// A third flop provides edge detection.
module ws2812_rx_sync (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic din_in,
   output logic din_s,
   output logic rise,
   output logic fall
);

   logic meta;
   logic din_d;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         meta  <= 1'b0;
         din_s <= 1'b0;
         din_d <= 1'b0;
      end else begin
         meta  <= din_in;
         din_s <= meta;
         din_d <= din_s;
      end
   end

   assign rise = din_s & ~din_d;
   assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 line receiver: pulse-width decode into 24-bit pixels,
// framed by the low reset code.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int HI_MIN  = DEF_HI_MIN,
   parameter int HI_THR  = DEF_HI_THR,
   parameter int HI_MAX  = DEF_HI_MAX,
   parameter int PIX_MAX = DEF_PIX_MAX
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        din_in,
   input  logic [15:0] rst_cnt_in,
   output logic        pix_valid_out,
   output pixel_t      pix_data_out,
   output logic [5:0]  pix_idx_out,
   output logic [6:0]  pix_cnt_out,
   output logic        frame_done_out,
   output logic        ovf_out,
   output logic        err_out,
   output logic        busy_out
);

   localparam int HW = $clog2(HI_MAX + 2);
   localparam logic [HW-1:0] H_MIN = HW'(HI_MIN);
   localparam logic [HW-1:0] H_THR = HW'(HI_THR);
   localparam logic [HW-1:0] H_MAX = HW'(HI_MAX);
   localparam logic [HW-1:0] H_SAT = HW'(HI_MAX + 1);
   localparam logic [6:0]    P_MAX = 7'(PIX_MAX);

   rx_state_e     state;
   rx_state_e     state_nx;
   logic          din_s;
   logic          rise;
   logic          fall;
   logic [HW-1:0] hi_cnt;
   logic [16:0]   lo_cnt;
   logic [16:0]   rst_thr;
   pixel_t        shift;
   logic [4:0]    bit_cnt;
   logic [6:0]    pix_idx;
   logic [5:0]    pend_idx;
   logic          ovf;
   logic          px_pend;
   logic          rst_hit;
   logic          bit_ok;
   logic          bit_val;
   logic          in_recv;
   logic          good_bit;
   logic          bad_bit;
   logic          pix_end;
   logic          frm_end;
   logic          room;

   ws2812_rx_sync u_sync (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .din_in   (din_in),
      .din_s    (din_s),
      .rise     (rise),
      .fall     (fall)
   );

   // lo_cnt still holds the previous gap during the fall cycle,
   // so the reset code is only trusted once the fall has passed.
   assign rst_thr  = (rst_cnt_in == 16'd0) ? 17'd2 : {rst_cnt_in, 1'b0};
   assign rst_hit  = ~din_s & ~fall & (lo_cnt >= rst_thr);
   assign bit_ok   = (hi_cnt >= H_MIN) && (hi_cnt <= H_MAX);
   assign bit_val  = hi_cnt >= H_THR;
   assign in_recv  = state == RECV;
   assign good_bit = in_recv & fall & bit_ok;
   assign bad_bit  = in_recv & fall & ~bit_ok;
   assign pix_end  = good_bit & (bit_cnt == 5'd23);
   assign frm_end  = in_recv & rst_hit;
   assign room     = pix_idx < P_MAX;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hi_cnt <= '0;
         lo_cnt <= '0;
      end else begin
         if (rise)
            hi_cnt <= '0;
         else if (din_s && hi_cnt != H_SAT)
            hi_cnt <= hi_cnt + 1'b1;
         if (fall)
            lo_cnt <= '0;
         else if (!din_s && lo_cnt != '1)
            lo_cnt <= lo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         state <= SYNC;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         SYNC: if (rst_hit) state_nx = IDLE;
         IDLE: if (rise) state_nx = RECV;
         RECV: begin
            if (bad_bit)
               state_nx = SYNC;
            else if (rst_hit)
               state_nx = IDLE;
         end
         default: state_nx = SYNC;
      endcase
   end

   always_comb begin
      busy_out = (state == RECV);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         shift    <= '0;
         bit_cnt  <= '0;
         pix_idx  <= '0;
         pend_idx <= '0;
         ovf      <= 1'b0;
         px_pend  <= 1'b0;
      end else begin
         px_pend <= pix_end & room;
         if (state == IDLE && rise) begin
            bit_cnt <= '0;
            pix_idx <= '0;
            ovf     <= 1'b0;
         end else if (good_bit) begin
            shift <= {shift[22:0], bit_val};
            if (pix_end) begin
               bit_cnt  <= '0;
               pend_idx <= pix_idx[5:0];
               if (room)
                  pix_idx <= pix_idx + 1'b1;
               else
                  ovf <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pix_valid_out  <= 1'b0;
         pix_data_out   <= '0;
         pix_idx_out    <= '0;
         pix_cnt_out    <= '0;
         frame_done_out <= 1'b0;
         ovf_out        <= 1'b0;
         err_out        <= 1'b0;
      end else begin
         pix_valid_out  <= px_pend;
         if (px_pend) begin
            pix_data_out <= shift;
            pix_idx_out  <= pend_idx;
         end
         err_out        <= bad_bit | (frm_end & (bit_cnt != 5'd0));
         frame_done_out <= frm_end & (bit_cnt == 5'd0);
         if (frm_end && bit_cnt == 5'd0) begin
            pix_cnt_out <= pix_idx;
            ovf_out     <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomized bench for ws2812_rx against a frame-level model:
// expected pixels, counts and flags follow from the sent values.
module tb_ws2812_rx;
   import ws2812_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        din   = 1'b0;
   logic [15:0] rc    = 16'd1500;

   logic       pv;
   pixel_t     pdata;
   logic [5:0] pidx;
   logic [6:0] pcnt;
   logic       fd;
   logic       ovf;
   logic       er;
   logic       busy;

   int n_chk    = 0;
   int n_err    = 0;
   int cyc      = 0;
   int fall_cyc = 0;
   int lat      = -1;
   int fd_n     = 0;
   int err_n    = 0;
   int excl_bad = 0;
   int gb       = 0;
   int fb       = 0;
   int eb       = 0;
   int exp_cnt  = 0;
   logic exp_ovf = 1'b0;
   logic [29:0] got_q[$];

   ws2812_rx dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .din_in         (din),
      .rst_cnt_in     (rc),
      .pix_valid_out  (pv),
      .pix_data_out   (pdata),
      .pix_idx_out    (pidx),
      .pix_cnt_out    (pcnt),
      .frame_done_out (fd),
      .ovf_out        (ovf),
      .err_out        (er),
      .busy_out       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (pv) begin
            got_q.push_back({pidx, pdata});
            if (lat < 0) lat = cyc - fall_cyc;
         end
         if (fd) fd_n++;
         if (er) err_n++;
         if (fd && er) excl_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      din = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input int hi, input int lo);
      hold(1'b1, hi);
      fall_cyc = cyc;
      hold(1'b0, lo);
   endtask

   task automatic send_rand_bit(input logic b);
      int hi;
      hi = b ? $urandom_range(40, 33) : $urandom_range(16, 11);
      send_bit(b, hi, $urandom_range(10, 4));
   endtask

   task automatic send_part(input pixel_t p, input int nb);
      for (int i = 23; i > 23 - nb; i--) send_rand_bit(p[i]);
   endtask

   task automatic send_pix(input pixel_t p);
      send_part(p, 24);
   endtask

   task automatic gap();
      hold(1'b0, 2 * int'(rc) + 100);
   endtask

   task automatic mark();
      gb = got_q.size();
      fb = fd_n;
      eb = err_n;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, {pv, fd, ovf, er, busy, pidx, pcnt}, 0);
      chk({tag, "_data"}, pdata, 0);
   endtask

   task automatic check_pix(input string tag, input pixel_t vals[$],
                            input int ne);
      chk({tag, "_npix"}, got_q.size() - gb, ne);
      for (int i = 0; i < ne; i++)
         if (gb + i < got_q.size())
            chk({tag, "_pix"}, got_q[gb + i], {6'(i), vals[i]});
   endtask

   // A good frame of n pixels: first 64 are emitted with idx = position.
   task automatic expect_frame(input string tag, input pixel_t vals[$]);
      int n;
      int ne;
      n  = vals.size();
      ne = (n < DEF_PIX_MAX) ? n : DEF_PIX_MAX;
      check_pix(tag, vals, ne);
      chk({tag, "_done"}, fd_n - fb, 1);
      chk({tag, "_err"}, err_n - eb, 0);
      chk({tag, "_cnt"}, pcnt, ne);
      chk({tag, "_ovf"}, ovf, n > DEF_PIX_MAX);
      if (ne > 0) begin
         chk({tag, "_hold_d"}, pdata, vals[ne - 1]);
         chk({tag, "_hold_i"}, pidx, ne - 1);
      end
      exp_cnt = ne;
      exp_ovf = n > DEF_PIX_MAX;
   endtask

   task automatic expect_none(input string tag, input int n_errs);
      chk({tag, "_npix"}, got_q.size() - gb, 0);
      chk({tag, "_done"}, fd_n - fb, 0);
      chk({tag, "_err"}, err_n - eb, n_errs);
      chk({tag, "_cnt"}, pcnt, exp_cnt);
      chk({tag, "_ovf"}, ovf, exp_ovf);
   endtask

   initial begin
      pixel_t vals[$];
      pixel_t p;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // basic frame with nominal timing
      mark();
      hold(1'b0, 3200);
      p = 24'hFF0080;
      for (int i = 23; i >= 0; i--)
         send_bit(p[i], p[i] ? 40 : 20, p[i] ? 22 : 42);
      hold(1'b0, 3200);
      vals.delete();
      vals.push_back(p);
      expect_frame("t1", vals);
      chk("t1_latency", lat, 4);

      // overflow: 65 pixels
      rc = 16'd300;
      gap();
      mark();
      vals.delete();
      for (int i = 0; i < 65; i++) begin
         vals.push_back(pixel_t'(i));
         send_pix(pixel_t'(i));
         if (i == 9) chk("t2_busy", busy, 1);
      end
      gap();
      expect_frame("t2", vals);

      // random frames with legal mid-frame low gaps
      for (int f = 0; f < 3; f++) begin
         rc = 16'($urandom_range(400, 200));
         gap();
         mark();
         vals.delete();
         for (int i = 0; i < int'($urandom_range(4, 1)); i++) begin
            p = pixel_t'($urandom);
            vals.push_back(p);
            send_pix(p);
            if ($urandom_range(1, 0) == 1)
               hold(1'b0, $urandom_range(int'(rc), 50));
         end
         gap();
         expect_frame("rnd", vals);
      end

      // short glitch mid-pixel
      rc = 16'd300;
      mark();
      send_part(pixel_t'($urandom), 10);
      hold(1'b1, 4);
      hold(1'b0, 20);
      chk("t3_busy", busy, 0);
      send_pix(pixel_t'($urandom));
      send_pix(pixel_t'($urandom));
      expect_none("t3", 1);
      gap();
      mark();
      vals.delete();
      p = pixel_t'($urandom);
      vals.push_back(p);
      send_pix(p);
      gap();
      expect_frame("t3_after", vals);

      // partial pixel ended by reset code
      rc = 16'd1500;
      mark();
      send_part(pixel_t'($urandom), 10);
      hold(1'b0, 3200);
      expect_none("t4", 1);

      // power-up with line high, no leading reset code
      rst_n = 1'b0;
      din   = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("t5_rst");
      exp_cnt = 0;
      exp_ovf = 1'b0;
      rst_n = 1'b1;
      rc = 16'd300;
      hold(1'b1, 500);
      mark();
      for (int i = 0; i < 3; i++) send_pix(pixel_t'($urandom));
      expect_none("t5", 0);
      gap();
      mark();
      vals.delete();
      p = pixel_t'($urandom);
      vals.push_back(p);
      send_pix(p);
      gap();
      expect_frame("t5_after", vals);

      // asynchronous reset in the middle of pixel 3
      mark();
      vals.delete();
      for (int i = 0; i < 4; i++) vals.push_back(pixel_t'($urandom));
      for (int i = 0; i < 3; i++) send_pix(vals[i]);
      send_part(vals[3], 12);
      #2 rst_n = 1'b0;
      #1 check_zero("t6_rst");
      chk("t6_done", fd_n - fb, 0);
      check_pix("t6_pre", vals, 3);
      exp_cnt = 0;
      exp_ovf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mark();
      for (int i = 11; i >= 0; i--) send_rand_bit(vals[3][i]);
      send_pix(pixel_t'($urandom));
      send_pix(pixel_t'($urandom));
      expect_none("t6_post", 0);
      gap();
      mark();
      vals.delete();
      p = pixel_t'($urandom);
      vals.push_back(p);
      send_pix(p);
      gap();
      expect_frame("t6_after", vals);

      chk("done_err_excl", excl_bad, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
